regfile_issue_sequencer: RTL and testbench

Multi-cycle control sequencer and initiator side of the register-file port. Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it. Drives register-file read addresses, opcode, write address, write enable and write data. Launches the ALU, waits for its result and performs a single write-back before accepting the next instruction. Sits between the instruction source and the register file/ALU pair of the 16-bit CPU.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/seq_timeout_counter.sv | 36 +++
 rtl/regfile_issue_sequencer.sv | 142 ++++++++++++++
 tb/tb_regfile_issue_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path:
// opcodes, instruction field positions and sequencer states.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int FIELD_W   = 4;
    localparam int CODOP_LSB = 12;
    localparam int C_LSB     = 8;
    localparam int A_LSB     = 4;
    localparam int B_LSB     = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_e;

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op >= 4'd6) || (op == 4'd2);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Loadable down-counter; expired is high once the count sits at zero.
// Loaded in READ so the first EXEC cycle sees MAX-1.
module seq_timeout_counter #(
    parameter  int MAX = 16,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic clk0,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(MAX - 1);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/regfile_issue_sequencer.sv
// Issue sequencer: accepts one instruction, drives the register-file
// port, launches the ALU and performs a single write-back.
module regfile_issue_sequencer
    import cpu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk0,
    input  logic                reset,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [3:0]          codop,
    output logic [3:0]          addrARead,
    output logic [3:0]          addrBRead,
    output logic [3:0]          addrCWrite,
    output logic                RWsignal,
    output logic [15:0]         data,
    output logic                imm_sel,
    output logic                alu_start,
    input  logic [15:0]         alu_result,
    input  logic                alu_valid,
    output logic                busy,
    output logic                halted,
    output logic                timeout_err,
    output logic [RETIRE_W-1:0] retired_count
);

    state_e              state_q, state_d;
    logic [15:0]         ir_q, ir_d;
    logic [15:0]         data_q, data_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                first_q, first_d;
    logic                tmo_q, tmo_d;
    logic                cnt_load;
    logic                cnt_en;
    logic                expired;
    logic [3:0]          op;

    assign op = ir_q[CODOP_LSB +: FIELD_W];

    seq_timeout_counter #(
        .MAX(ALU_TIMEOUT)
    ) u_tmo (
        .clk0   (clk0),
        .reset  (reset),
        .load   (cnt_load),
        .en     (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            data_q    <= '0;
            retired_q <= '0;
            first_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            data_q    <= data_d;
            retired_q <= retired_d;
            first_q   <= first_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        data_d    = data_q;
        retired_d = retired_q;
        first_d   = 1'b0;
        tmo_d     = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (op == OP_NOP) begin
                    retired_d = retired_q + RETIRE_W'(1);
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_load = 1'b1;
                first_d  = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                cnt_en = 1'b1;
                // a result arriving on the expiry cycle still wins
                if (alu_valid) begin
                    data_d  = alu_result;
                    state_d = S_WB;
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_IDLE;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        instr_ready   = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
        halted        = (state_q == S_HALTED);
        RWsignal      = (state_q == S_WB);
        alu_start     = first_q && (state_q == S_EXEC);
        timeout_err   = tmo_q;
        codop         = op;
        addrCWrite    = ir_q[C_LSB +: FIELD_W];
        addrARead     = ir_q[A_LSB +: FIELD_W];
        addrBRead     = ir_q[B_LSB +: FIELD_W];
        imm_sel       = is_imm_op(op);
        data          = data_q;
        retired_count = retired_q;
    end

endmodule

// File: tb/tb_regfile_issue_sequencer.sv
// Directed bench for regfile_issue_sequencer: vector table plus
// hand-written reset, halt and back-to-back sequences.
module tb_regfile_issue_sequencer;

    logic        clk0 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [15:0] alu_result = '0;
    logic        alu_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  codop;
    logic [3:0]  addrARead;
    logic [3:0]  addrBRead;
    logic [3:0]  addrCWrite;
    logic        RWsignal;
    logic [15:0] data;
    logic        imm_sel;
    logic        alu_start;
    logic        busy;
    logic        halted;
    logic        timeout_err;
    logic [1:0]  retired_count;

    regfile_issue_sequencer #(
        .ALU_TIMEOUT(4),
        .RETIRE_W   (2)
    ) dut (
        .clk0         (clk0),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .codop        (codop),
        .addrARead    (addrARead),
        .addrBRead    (addrBRead),
        .addrCWrite   (addrCWrite),
        .RWsignal     (RWsignal),
        .data         (data),
        .imm_sel      (imm_sel),
        .alu_start    (alu_start),
        .alu_result   (alu_result),
        .alu_valid    (alu_valid),
        .busy         (busy),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .retired_count(retired_count)
    );

    always #5 clk0 = ~clk0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] instr;
        int          k;
        logic [15:0] res;
        int          ready;
        bit          rw;
        bit          tmo;
        bit          imm;
        logic [1:0]  ret;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk0);
        reset = 1'b0;
    endtask

    // k = EXEC cycle (1 = alu_start cycle) carrying alu_valid, 0 = never
    task automatic run_vec(input vec_t v, input string nm);
        int          cyc = 0;
        int          starts = 0;
        int          st_cyc = -1;
        int          rws = 0;
        int          tmos = 0;
        int          abad = 0;
        logic [3:0]  wa = '0;
        logic [15:0] wd = '0;
        bit          is_nop;
        is_nop = (v.instr[15:12] == 4'hE);
        chk({nm, ".ready_in"}, 32'(instr_ready), 32'd1);
        instr       = v.instr;
        instr_valid = 1'b1;
        @(negedge clk0);
        instr_valid = 1'b0;
        cyc = 1;
        chk({nm, ".imm_sel"}, 32'(imm_sel), 32'(v.imm));
        chk({nm, ".codop"}, 32'(codop), 32'(v.instr[15:12]));
        chk({nm, ".addrB"}, 32'(addrBRead), 32'(v.instr[3:0]));
        chk({nm, ".addrA"}, 32'(addrARead), 32'(v.instr[7:4]));
        while (cyc < 30) begin
            if (alu_start) begin
                starts++;
                st_cyc = cyc;
            end
            if (RWsignal) begin
                rws++;
                wa = addrCWrite;
                wd = data;
            end
            if (timeout_err) tmos++;
            if (busy && (addrBRead != v.instr[3:0] ||
                         addrCWrite != v.instr[11:8] ||
                         imm_sel != v.imm)) abad++;
            if (instr_ready) break;
            alu_valid  = (v.k != 0) && (cyc == 2 + v.k);
            alu_result = alu_valid ? v.res : 16'h5A5A;
            @(negedge clk0);
            cyc++;
        end
        alu_valid = 1'b0;
        chk({nm, ".ready_cyc"}, 32'(cyc), 32'(v.ready));
        chk({nm, ".rw_count"}, 32'(rws), 32'(v.rw));
        if (rws != 0) begin
            chk({nm, ".wb_addr"}, 32'(wa), 32'(v.instr[11:8]));
            chk({nm, ".wb_data"}, 32'(wd), 32'(v.res));
        end
        chk({nm, ".timeout"}, 32'(tmos), 32'(v.tmo));
        chk({nm, ".starts"}, 32'(starts), is_nop ? 32'd0 : 32'd1);
        if (starts != 0) chk({nm, ".start_cyc"}, 32'(st_cyc), 32'd3);
        chk({nm, ".stable"}, 32'(abad), 32'd0);
        chk({nm, ".retired"}, 32'(retired_count), 32'(v.ret));
    endtask

    initial begin
        int       hbad;
        int       cnt;
        int       starts;
        int       last_cyc;
        logic [1:0] prev;
        logic [1:0] seen[$];
        logic [1:0] exp_seq[5];

        vecs[0] = '{16'h1312, 1, 16'hABCD, 5, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[1] = '{16'h6457, 2, 16'h1111, 6, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{16'h2A5B, 0, 16'h0000, 7, 1'b0, 1'b1, 1'b1, 2'd2};
        vecs[3] = '{16'h3C12, 4, 16'hBEEF, 8, 1'b1, 1'b0, 1'b0, 2'd3};
        vecs[4] = '{16'hE000, 0, 16'h0000, 2, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[5] = '{16'h0055, 3, 16'h0000, 7, 1'b1, 1'b0, 1'b0, 2'd1};
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        @(negedge clk0);
        do_reset();
        chk("rst.ready", 32'(instr_ready), 32'd1);
        chk("rst.ctl", {27'd0, RWsignal, alu_start, imm_sel,
                        timeout_err, halted}, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.addr", {16'd0, codop, addrARead, addrBRead, addrCWrite},
            32'd0);
        chk("rst.data", 32'(data), 32'd0);
        chk("rst.retired", 32'(retired_count), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // HALT holds off further instructions until reset
        instr       = 16'hF000;
        instr_valid = 1'b1;
        @(negedge clk0);
        instr = 16'h1312;
        @(negedge clk0);
        hbad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!halted || instr_ready || busy) hbad++;
            @(negedge clk0);
        end
        instr_valid = 1'b0;
        chk("halt.held", 32'(hbad), 32'd0);
        chk("halt.retired", 32'(retired_count), 32'd1);
        do_reset();
        chk("halt.cleared", 32'(halted), 32'd0);
        chk("halt.ready", 32'(instr_ready), 32'd1);

        // reset during EXEC
        run_vec(vecs[0], "pre_exec");
        instr       = 16'h1312;
        instr_valid = 1'b1;
        @(negedge clk0);
        instr_valid = 1'b0;
        @(negedge clk0);
        @(negedge clk0);
        chk("exec_rst.start", 32'(alu_start), 32'd1);
        do_reset();
        chk("exec_rst.ctl", {28'd0, RWsignal, busy, timeout_err,
                             instr_ready}, 32'd1);
        chk("exec_rst.data", 32'(data), 32'd0);
        chk("exec_rst.addr", {16'd0, codop, addrARead, addrBRead,
                              addrCWrite}, 32'd0);
        chk("exec_rst.retired", 32'(retired_count), 32'd0);

        // reset during WB
        instr       = 16'h1312;
        instr_valid = 1'b1;
        @(negedge clk0);
        instr_valid = 1'b0;
        @(negedge clk0);
        @(negedge clk0);
        alu_valid  = 1'b1;
        alu_result = 16'hABCD;
        @(negedge clk0);
        alu_valid = 1'b0;
        chk("wb_rst.in_wb", 32'(RWsignal), 32'd1);
        do_reset();
        chk("wb_rst.ctl", {29'd0, RWsignal, busy, instr_ready}, 32'd1);
        chk("wb_rst.data", 32'(data), 32'd0);
        chk("wb_rst.retired", 32'(retired_count), 32'd0);

        // alu_valid while IDLE is ignored
        alu_valid  = 1'b1;
        alu_result = 16'h1234;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            if (RWsignal || busy) cnt++;
        end
        alu_valid = 1'b0;
        chk("idle_valid.ctl", 32'(cnt), 32'd0);
        chk("idle_valid.data", 32'(data), 32'd0);

        // back-to-back with wrap of the 2-bit retire counter
        do_reset();
        instr       = 16'h1312;
        instr_valid = 1'b1;
        alu_valid   = 1'b1;
        alu_result  = 16'h0F0F;
        prev        = retired_count;
        starts      = 0;
        last_cyc    = -1;
        for (int c = 0; c < 40; c++) begin
            if (alu_start) starts++;
            if (retired_count != prev) begin
                seen.push_back(retired_count);
                prev = retired_count;
            end
            if (seen.size() == 5) begin
                last_cyc = c;
                break;
            end
            @(negedge clk0);
        end
        instr_valid = 1'b0;
        alu_valid   = 1'b0;
        chk("b2b.count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size())
                chk($sformatf("b2b.ret%0d", i), 32'(seen[i]),
                    32'(exp_seq[i]));
        end
        chk("b2b.last_cyc", 32'(last_cyc), 32'd25);
        chk("b2b.starts", 32'(starts), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
